// File: rtl/parity_seq_detector.sv
// Programmable parity-sequence detector: matches the LSB parity of valid samples against a loadable pattern.
// Optional idle-gap abandonment of partial sequences is compiled in with `define PPD_GAP_TIMEOUT_EN.
`timescale 1ns/1ps
module parity_seq_detector #(
    parameter int                 DATA_W      = 4,
    parameter int                 PAT_LEN     = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [PAT_LEN-1:0] DEF_PATTERN = 4'b0110,
    parameter int                 DEF_LEN     = 4,
    parameter int                 GAP_MAX     = 16,
    localparam int                LEN_W       = $clog2(PAT_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  in,
    input  logic               valid,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               sequence_detected,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   fill,
    output logic               gap_timeout
);

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PAT_LEN);
    localparam logic [LEN_W-1:0] DEF_LEN_C =
        (DEF_LEN < 1 || DEF_LEN > PAT_LEN) ? FULL_LEN : LEN_W'(DEF_LEN);

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               det_q, det_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [PAT_LEN-1:0] hist_shift;
    logic [PAT_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   cfg_len_clamped;
    logic               accept;
    logic               match;

    // Only the parity bit of a sample matters; fold the rest so nothing is left dangling.
    logic unused_in_bits;
    assign unused_in_bits = ^in;

    genvar gi;
    generate
        for (gi = 0; gi < PAT_LEN; gi++) begin : g_mask
            assign len_mask[gi] = (LEN_W'(gi) < len_q);
        end
    endgenerate

    assign hist_shift      = {hist_q[PAT_LEN-2:0], in[0]};
    assign fill_inc        = (fill_q == FULL_LEN) ? fill_q : fill_q + 1'b1;
    assign cfg_len_clamped = (cfg_len == '0 || cfg_len > FULL_LEN) ? FULL_LEN : cfg_len;
    assign accept          = valid && !cfg_load;
    assign match           = accept && (fill_inc >= len_q) &&
                             (((hist_shift ^ pat_q) & len_mask) == '0);

`ifdef PPD_GAP_TIMEOUT_EN
    localparam int               GAP_W   = $clog2(GAP_MAX + 1);
    localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'(GAP_MAX);

    logic [GAP_W-1:0] gap_q, gap_d;
    logic             gto_q, gto_d;
`endif

    always_comb begin
        hist_d = hist_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        fill_d = fill_q;
        det_d  = match;
        cnt_d  = cnt_q;
`ifdef PPD_GAP_TIMEOUT_EN
        gap_d  = gap_q;
        gto_d  = 1'b0;
`endif

        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = cfg_len_clamped;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (valid) begin
            hist_d = hist_shift;
            // Without overlap the next match must be built entirely from new samples.
            fill_d = (match && !ovl_q) ? '0 : fill_inc;
        end

`ifdef PPD_GAP_TIMEOUT_EN
        if (valid || cfg_load) begin
            gap_d = '0;
        end else if (gap_q != GAP_TOP) begin
            gap_d = gap_q + 1'b1;
            if (gap_d == GAP_TOP && fill_q != '0) begin
                fill_d = '0;
                gto_d  = 1'b1;
            end
        end
`endif

        if (clr_count) begin
            cnt_d = CNT_W'(match);
        end else if (match && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            pat_q  <= DEF_PATTERN;
            len_q  <= DEF_LEN_C;
            ovl_q  <= 1'b1;
            fill_q <= '0;
            det_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            fill_q <= fill_d;
            det_q  <= det_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef PPD_GAP_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= '0;
            gto_q <= 1'b0;
        end else begin
            gap_q <= gap_d;
            gto_q <= gto_d;
        end
    end

    assign gap_timeout = gto_q;
`else
    assign gap_timeout = 1'b0;
`endif

    assign sequence_detected = det_q;
    assign match_count       = cnt_q;
    assign fill              = fill_q;

endmodule

// File: tb/tb_parity_seq_detector.sv
// Scoreboard bench for parity_seq_detector: a sample-queue reference model pushes expected outputs per cycle.
`timescale 1ns/1ps
module tb_parity_seq_detector;

    localparam int DATA_W  = 4;
    localparam int PAT_LEN = 4;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(PAT_LEN + 1);
    localparam int GAP_MAX = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [DATA_W-1:0]  in;
    logic               valid;
    logic               cfg_load;
    logic [PAT_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               clr_count;
    logic               sequence_detected;
    logic [CNT_W-1:0]   match_count;
    logic [LEN_W-1:0]   fill;
    logic               gap_timeout;

    parity_seq_detector #(
        .DATA_W(DATA_W), .PAT_LEN(PAT_LEN), .CNT_W(CNT_W),
        .DEF_PATTERN(4'b0110), .DEF_LEN(4), .GAP_MAX(GAP_MAX)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .in(in), .valid(valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .clr_count(clr_count),
        .sequence_detected(sequence_detected), .match_count(match_count),
        .fill(fill), .gap_timeout(gap_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit det;
        int cnt;
        int fill;
        bit gto;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: raw parities since the last clear, newest at the back.
    bit             sq[$];
    logic [3:0]     m_pat;
    int             m_len;
    bit             m_ovl;
    int             m_cnt;
    int             m_idle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        sq.delete();
        m_pat  = 4'b0110;
        m_len  = 4;
        m_ovl  = 1'b1;
        m_cnt  = 0;
        m_idle = 0;
    endtask

    task automatic drive(input bit v, input logic [3:0] d, input bit ld = 1'b0,
                         input logic [3:0] p = 4'b0, input int l = 0,
                         input bit o = 1'b1, input bit clr = 1'b0);
        exp_t e;
        exp_t got;
        bit   ok;
        valid = v; in = d; cfg_load = ld; cfg_pattern = p;
        cfg_len = LEN_W'(l); cfg_overlap = o; clr_count = clr;
        e.det = 1'b0;
        e.gto = 1'b0;
        if (ld) begin
            m_pat  = p;
            m_len  = (l == 0 || l > PAT_LEN) ? PAT_LEN : l;
            m_ovl  = o;
            m_idle = 0;
            sq.delete();
        end else if (v) begin
            m_idle = 0;
            sq.push_back(d[0]);
            if (sq.size() > PAT_LEN) void'(sq.pop_front());
            if (sq.size() >= m_len) begin
                ok = 1'b1;
                for (int k = 0; k < m_len; k++)
                    if (sq[sq.size() - 1 - k] != m_pat[k]) ok = 1'b0;
                if (ok) begin
                    e.det = 1'b1;
                    if (!m_ovl) sq.delete();
                end
            end
        end else begin
`ifdef PPD_GAP_TIMEOUT_EN
            if (m_idle < GAP_MAX) begin
                m_idle++;
                if (m_idle == GAP_MAX && sq.size() != 0) begin
                    sq.delete();
                    e.gto = 1'b1;
                end
            end
`endif
        end
        if (clr) m_cnt = e.det ? 1 : 0;
        else if (e.det && m_cnt < CNT_MAX) m_cnt++;
        e.cnt  = m_cnt;
        e.fill = sq.size();
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk("det",  32'(sequence_detected), 32'(got.det));
        chk("cnt",  32'(match_count),       32'(got.cnt));
        chk("fill", 32'(fill),              32'(got.fill));
        chk("gto",  32'(gap_timeout),       32'(got.gto));
        $display("txn v=%0b in=%0d ld=%0b clr=%0b -> det=%0b cnt=%0d fill=%0d gto=%0b",
                 v, d, ld, clr, sequence_detected, match_count, fill, gap_timeout);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'($urandom_range(0, 15)));
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_det",  32'(sequence_detected), 32'd0);
        chk("rst_cnt",  32'(match_count),       32'd0);
        chk("rst_fill", 32'(fill),              32'd0);
        chk("rst_gto",  32'(gap_timeout),       32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; in = '0; valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b1; clr_count = 1'b0;
        #2;
        async_reset();

        // Defaults, back-to-back
        drive(1, 2); drive(1, 5); drive(1, 7); drive(1, 4);
        chk("t1_det", 32'(sequence_detected), 32'd1);
        chk("t1_cnt", 32'(match_count), 32'd1);
        chk("t1_fill", 32'(fill), 32'd4);
        drive(0, 0);
        chk("t1_pulse_once", 32'(sequence_detected), 32'd0);

        // Default pattern with idle gaps and toggling data
        drive(1, 2); idle(3); drive(1, 5); drive(1, 7); idle(1); drive(1, 4);
        chk("t2_cnt", 32'(match_count), 32'd2);

        // 3-long pattern, overlapping then non-overlapping
        drive(0, 0, 1, 4'b0010, 3, 1);
        drive(1, 2); drive(1, 3); drive(1, 4); drive(1, 5); drive(1, 6);
        drive(1, 0, 1, 4'b0010, 3, 0, 1);
        drive(1, 2); drive(1, 3); drive(1, 4); drive(1, 5); drive(1, 6);
        chk("t3_cnt", 32'(match_count), 32'd1);

        // Length clamp (0 and 5 -> 4) and load-wins-over-valid
        drive(1, 1, 1, 4'b1111, 0, 1);
        drive(1, 1); drive(1, 3); drive(1, 5); drive(1, 7);
        drive(1, 1, 1, 4'b1111, 5, 1);
        drive(1, 3); drive(1, 5); drive(1, 7); drive(1, 9); drive(1, 11);

        // Reset mid-sequence restores default config and clears count
        drive(0, 0, 1, 4'b1001, 4, 0);
        drive(1, 2); drive(1, 5); drive(1, 7);
        async_reset();
        drive(1, 4);
        chk("t4_det", 32'(sequence_detected), 32'd0);
        chk("t4_cnt", 32'(match_count), 32'd0);
        drive(1, 2); drive(1, 5); drive(1, 7); drive(1, 4);
        chk("t4_default_pat", 32'(sequence_detected), 32'd1);

        // Saturation, then clear with and without a coincident match
        drive(0, 0, 1, 4'b0001, 1, 1);
        for (int i = 0; i < CNT_MAX + 5; i++) drive(1, 4'($urandom_range(0, 7) * 2 + 1));
        chk("sat_cnt", 32'(match_count), 32'(CNT_MAX));
        drive(1, 3, 0, 0, 0, 1, 1);
        chk("clr_match_cnt", 32'(match_count), 32'd1);
        drive(1, 3);
        drive(0, 0, 0, 0, 0, 1, 1);
        chk("clr_only_cnt", 32'(match_count), 32'd0);

        // Idle gap of GAP_MAX cycles across a partial sequence
        drive(0, 0, 1, 4'b0110, 4, 1);
        drive(1, 2); drive(1, 5); idle(GAP_MAX);
`ifdef PPD_GAP_TIMEOUT_EN
        chk("gap_gto", 32'(gap_timeout), 32'd1);
        chk("gap_fill", 32'(fill), 32'd0);
`else
        chk("gap_gto", 32'(gap_timeout), 32'd0);
        chk("gap_fill", 32'(fill), 32'd2);
`endif
        drive(1, 7); drive(1, 4);
`ifdef PPD_GAP_TIMEOUT_EN
        chk("gap_det", 32'(sequence_detected), 32'd0);
`else
        chk("gap_det", 32'(sequence_detected), 32'd1);
`endif
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
